// File: rtl/mem_access_unit.sv
// Purpose : MEM-stage initiator for the doubleword data memory. Loads, doubleword stores,
//           and read-modify-write stores of byte/half/word.
// Latency : done 2 cycles after accept for loads and doubleword stores, 3 for RMW stores,
//           1 for faulting requests.
// Backpr. : busy is high while a request is in flight. start is ignored until the unit is IDLE again.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start, is_load,       request strobe (only sampled in IDLE) and kind; both kinds set = load
//   is_store
//   size, sign_ext        access width (00 b, 01 h, 10 w, 11 d) and load extension mode
//   byte_addr, store_data byte address and right-justified store value
//   load_data, done,      extended load result, completion pulse, stall
//   busy
//   fault                 bit0 misaligned, bit1 out of range; valid with done
//   Address, DataWrite,   doubleword index, write data, read strobe, write strobe
//   MemRead, MemWrite
//   DataRead              combinational read data for Address
module mem_access_unit #(
  parameter int MEM_DWORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [63:0] byte_addr,
  input  logic [63:0] store_data,
  output logic [63:0] load_data,
  output logic        done,
  output logic        busy,
  output logic [1:0]  fault,
  output logic [63:0] Address,
  output logic [63:0] DataWrite,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [63:0] DataRead
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic [1:0]  req_fault;
  logic        misalign;
  logic        out_of_range;

  // Latched request
  logic        is_load_q;
  logic [1:0]  size_q;
  logic        sign_ext_q;
  logic [2:0]  off_q;
  logic [63:0] sdata_q;

  // Lane datapath
  logic [6:0]  field_w;
  logic [6:0]  shamt;
  logic [63:0] field_mask;
  logic [63:0] field;
  logic [63:0] ext_field;
  logic [63:0] merged;

  assign accept = (state == IDLE) && start && (is_load || is_store);

  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b01:   misalign = byte_addr[0];
      2'b10:   misalign = |byte_addr[1:0];
      2'b11:   misalign = |byte_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end

  assign out_of_range = ({3'b000, byte_addr[63:3]} >= 64'(MEM_DWORDS));
  assign req_fault    = {out_of_range, misalign};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault != 2'b00)  state_nxt = DONE;
          else if (is_load)        state_nxt = RD;
          else if (size == 2'b11)  state_nxt = WR;
          else                     state_nxt = RD;
        end
      end
      RD:      state_nxt = is_load_q ? DONE : WR;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign MemRead  = (state == RD);
  assign MemWrite = (state == WR);
  assign done     = (state == DONE);
  assign busy     = (state != IDLE);

  // Big-endian lanes: offset o, width w bits sits at DataRead[63-8o -: w],
  // i.e. its LSB is at bit 64 - 8o - w.
  always_comb begin
    field_w = 7'd64;
    case (size_q)
      2'b00:   field_w = 7'd8;
      2'b01:   field_w = 7'd16;
      2'b10:   field_w = 7'd32;
      default: field_w = 7'd64;
    endcase
  end

  assign shamt      = 7'd64 - {1'b0, off_q, 3'b000} - field_w;
  assign field_mask = (size_q == 2'b11) ? '1 : ((64'd1 << field_w) - 64'd1);
  assign field      = (DataRead >> shamt) & field_mask;
  assign merged     = (DataRead & ~(field_mask << shamt)) | ((sdata_q & field_mask) << shamt);

  always_comb begin
    ext_field = field;
    case (size_q)
      2'b00:   ext_field = {{56{sign_ext_q & field[7]}},  field[7:0]};
      2'b01:   ext_field = {{48{sign_ext_q & field[15]}}, field[15:0]};
      2'b10:   ext_field = {{32{sign_ext_q & field[31]}}, field[31:0]};
      default: ext_field = field;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      load_data  <= '0;
      fault      <= '0;
      Address    <= '0;
      DataWrite  <= '0;
      is_load_q  <= 1'b0;
      size_q     <= '0;
      sign_ext_q <= 1'b0;
      off_q      <= '0;
      sdata_q    <= '0;
    end else begin
      if (accept) begin
        Address    <= {3'b000, byte_addr[63:3]};
        off_q      <= byte_addr[2:0];
        size_q     <= size;
        sign_ext_q <= sign_ext;
        is_load_q  <= is_load;
        sdata_q    <= store_data;
        fault      <= req_fault;
        if (!is_load && size == 2'b11) DataWrite <= store_data;
      end
      // RD is only entered for fault-free requests; capture at the end of the read cycle.
      if (state == RD) begin
        if (is_load_q) load_data <= ext_field;
        else           DataWrite <= merged;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, is_store, sign_ext;
  logic [1:0]  size;
  logic [63:0] byte_addr, store_data;
  logic [63:0] load_data, Address, DataWrite, DataRead;
  logic        done, busy, MemRead, MemWrite;
  logic [1:0]  fault;

  mem_access_unit #(.MEM_DWORDS(128)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
    .size(size), .sign_ext(sign_ext), .byte_addr(byte_addr), .store_data(store_data),
    .load_data(load_data), .done(done), .busy(busy), .fault(fault), .Address(Address),
    .DataWrite(DataWrite), .MemRead(MemRead), .MemWrite(MemWrite), .DataRead(DataRead)
  );

  always #5 clk = ~clk;

  // Physical memory seen by the DUT
  logic [63:0] mem [0:127];
  int          wr_total = 0;
  assign DataRead = (Address < 64'd128) ? mem[Address[6:0]] : 64'd0;
  always @(posedge clk) begin
    if (MemWrite) begin
      if (Address < 64'd128) mem[Address[6:0]] <= DataWrite;
      wr_total <= wr_total + 1;
    end
  end

  // Reference model: a flat big-endian byte array plus the last loaded value
  logic [7:0]  rb [0:1023];
  logic [63:0] exp_ld;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_dword(input int base);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < 8; i++) v = (v << 8) | 64'(rb[base + i]);
    return v;
  endfunction

  // Issue one request, follow it to done, check it against the byte model.
  task automatic do_req(input logic l, input logic s, input logic [1:0] sz, input logic sx,
                        input logic [63:0] a, input logic [63:0] d,
                        output logic [1:0] f_o, output int lat_o, output logic [63:0] wd_o);
    int          n, cyc, rds, wrs, busy_n, base;
    logic        got_done, addr_bad, exp_wr;
    logic [1:0]  ef;
    logic [63:0] v, exp_dw;
    n = 1 << sz;
    ef[0] = (a & 64'(n - 1)) != 64'd0;
    ef[1] = (a >> 3) >= 64'd128;
    base = int'(a[9:0]) & ~7;

    @(negedge clk);
    start = 1'b1; is_load = l; is_store = s; size = sz; sign_ext = sx;
    byte_addr = a; store_data = d;
    cyc = 0; rds = 0; wrs = 0; busy_n = 0; got_done = 1'b0; addr_bad = 1'b0;
    f_o = 2'b00; wd_o = 64'd0;
    while (!got_done && cyc < 10) begin
      @(negedge clk);
      cyc++;
      // Garbage request held on the bus while busy must be ignored.
      byte_addr = {$urandom, $urandom}; store_data = {$urandom, $urandom};
      size = 2'($urandom); is_load = 1'($urandom); is_store = 1'($urandom);
      sign_ext = 1'($urandom);
      if (busy) busy_n++;
      if (MemRead) begin rds++; if (Address !== (a >> 3)) addr_bad = 1'b1; end
      if (MemWrite) begin
        wrs++; wd_o = DataWrite;
        if (Address !== (a >> 3)) addr_bad = 1'b1;
      end
      if (done) begin got_done = 1'b1; f_o = fault; end
    end
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    lat_o = cyc;

    chk("done_seen", 64'(got_done), 64'd1);
    chk("fault", 64'(f_o), 64'(ef));
    chk("latency", 64'(cyc), (ef != 0) ? 64'd1 : (l || sz == 2'b11) ? 64'd2 : 64'd3);
    chk("busy_cycles", 64'(busy_n), 64'(cyc));
    chk("rd_strobes", 64'(rds), (ef != 0) ? 64'd0 : (l || sz != 2'b11) ? 64'd1 : 64'd0);
    chk("wr_strobes", 64'(wrs), (ef == 0 && !l) ? 64'd1 : 64'd0);
    chk("strobe_addr", 64'(addr_bad), 64'd0);

    exp_wr = (ef == 0) && !l;
    if (ef == 0 && l) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 64'(rb[int'(a[9:0]) + i]);
      if (sz != 2'b11 && sx && v[8*n-1]) v = v | (~64'd0 << (8*n));
      exp_ld = v;
    end
    if (exp_wr) begin
      for (int i = 0; i < n; i++) rb[int'(a[9:0]) + i] = 8'(d >> (8*(n-1-i)));
      exp_dw = ref_dword(base);
      chk("datawrite", wd_o, exp_dw);
    end
    chk("load_data", load_data, exp_ld);
  endtask

  typedef struct {
    logic        ld, st;
    logic [1:0]  sz;
    logic        sx;
    logic [63:0] a, d;
    logic [1:0]  ef;
    int          el;
    logic [63:0] eld, edw;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [1:0]  f;
    int          lat, wbefore, k;
    logic [63:0] wd;

    tbl[0]  = '{1'b0, 1'b1, 2'd3, 1'b0, 64'h10,  64'h0011223344556677, 2'd0, 2, 64'h0, 64'h0011223344556677};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 64'h13,  64'h0, 2'd0, 2, 64'h33, 64'h0};
    tbl[2]  = '{1'b0, 1'b1, 2'd3, 1'b0, 64'h18,  64'h8899AABBCCDDEEFF, 2'd0, 2, 64'h33, 64'h8899AABBCCDDEEFF};
    tbl[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 64'h1A,  64'h0, 2'd0, 2, 64'hFFFFFFFFFFFFAABB, 64'h0};
    tbl[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 64'h1A,  64'h0, 2'd0, 2, 64'h000000000000AABB, 64'h0};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 1'b0, 64'h15,  64'hFFFFFFFFFFFFFF5A, 2'd0, 3, 64'hAABB, 64'h00112233445A6677};
    tbl[6]  = '{1'b1, 1'b0, 2'd2, 1'b0, 64'h22,  64'h0, 2'd1, 1, 64'hAABB, 64'h0};
    tbl[7]  = '{1'b1, 1'b0, 2'd3, 1'b0, 64'h400, 64'h0, 2'd2, 1, 64'hAABB, 64'h0};
    tbl[8]  = '{1'b1, 1'b0, 2'd3, 1'b1, 64'h10,  64'h0, 2'd0, 2, 64'h00112233445A6677, 64'h0};
    tbl[9]  = '{1'b1, 1'b1, 2'd1, 1'b1, 64'h1C,  64'h0, 2'd0, 2, 64'hFFFFFFFFFFFFCCDD, 64'h0};
    tbl[10] = '{1'b0, 1'b1, 2'd2, 1'b0, 64'h3FE, 64'h0, 2'd1, 1, 64'hFFFFFFFFFFFFCCDD, 64'h0};
    tbl[11] = '{1'b0, 1'b1, 2'd1, 1'b0, 64'h401, 64'h0, 2'd3, 1, 64'hFFFFFFFFFFFFCCDD, 64'h0};
    tbl[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 64'h1C,  64'h12345678, 2'd0, 3, 64'hFFFFFFFFFFFFCCDD, 64'h8899AABB12345678};
    tbl[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 64'h18,  64'h0, 2'd0, 2, 64'hFFFFFFFFFFFFFF88, 64'h0};

    for (int i = 0; i < 128; i++) mem[i] = 64'd0;
    for (int i = 0; i < 1024; i++) rb[i] = 8'd0;
    exp_ld = 64'd0;
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; size = 2'd0;
    sign_ext = 1'b0; byte_addr = 64'd0; store_data = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_load_data", load_data, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_address", Address, 64'd0);
    chk("rst_datawrite", DataWrite, 64'd0);
    chk("rst_memread", 64'(MemRead), 64'd0);
    chk("rst_memwrite", 64'(MemWrite), 64'd0);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      do_req(tbl[i].ld, tbl[i].st, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].d, f, lat, wd);
      chk($sformatf("tbl%0d_fault", i), 64'(f), 64'(tbl[i].ef));
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].el));
      chk($sformatf("tbl%0d_load_data", i), load_data, tbl[i].eld);
      if (!tbl[i].ld && tbl[i].ef == 2'd0) chk($sformatf("tbl%0d_datawrite", i), wd, tbl[i].edw);
    end

    // start with neither kind set is ignored
    @(negedge clk);
    start = 1'b1; is_load = 1'b0; is_store = 1'b0; byte_addr = 64'h10;
    k = 0;
    repeat (3) begin @(negedge clk); if (busy || MemRead || MemWrite) k++; end
    start = 1'b0;
    chk("no_kind_ignored", 64'(k), 64'd0);

    // Reset during the RD cycle of a byte store: abandoned, nothing written
    wbefore = wr_total;
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; size = 2'd0; byte_addr = 64'h10; store_data = 64'hEE;
    @(negedge clk);
    start = 1'b0; is_store = 1'b0;
    chk("rmw_in_rd", 64'(MemRead), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ld = 64'd0;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_memwrite", 64'(MemWrite), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_mid_no_write", 64'(wr_total), 64'(wbefore));
    do_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h10, 64'h0, f, lat, wd);
    chk("rst_mid_mem_kept", load_data, 64'h00112233445A6677);

    // Randomized requests against the byte model
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_req(kind != 1, kind != 0, 2'($urandom), 1'($urandom),
             64'($urandom_range(0, 1055)), {$urandom, $urandom}, f, lat, wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
